// File: rtl/cork_batch_dispenser_if.sv
// Cork transmit handshake between the batch dispenser (master) and the main
// cork buffer (slave). One cork moves per beat where tx_valid & tx_ready.
interface cork_batch_dispenser_if;
  logic tx_valid;
  logic tx_last;
  logic tx_ready;

  modport master (
    output tx_valid,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_last,
    output tx_ready
  );
endinterface

// File: rtl/cork_batch_dispenser.sv
// Warehouse cork stock and batch sender toward the main cork buffer.
// A batch of Batch corks is sent, one per handshake, whenever the buffer
// raises demand and enough stock is held. Stock saturates at StockMax.
// Optional feature macro: CORK_PARTIAL_BATCH_EN (allow short final batches
// of min(stock, Batch) corks whenever any stock is present).
module cork_batch_dispenser #(
  parameter int unsigned Batch    = 20,
  parameter int unsigned StockMax = 99,
  parameter int unsigned W        = 7
) (
  input  logic                          clk,
  input  logic                          Nrst,
  input  logic                          enable_i,
  input  logic                          stock_add_i,
  input  logic                          demand_i,
  cork_batch_dispenser_if.master        tx,
  output logic                          batch_done_o,
  output logic [W-1:0]                  stock_o,
  output logic                          starve_o,
  output logic                          overflow_o
);

  localparam logic [W-1:0] BatchW    = W'(Batch);
  localparam logic [W-1:0] StockMaxW = W'(StockMax);

  typedef enum logic [1:0] {StIdle, StSend, StPause, StDone} state_e;

  state_e         state_q;
  logic [W-1:0]   sent_q;
  logic [W-1:0]   stock_q, stock_d;
  logic           overflow_q, overflow_d;
  logic [W-1:0]   len;
  logic           hs;
  logic           start_ok;
  logic           start;
  logic           last;

`ifdef CORK_PARTIAL_BATCH_EN
  logic [W-1:0]   len_q;
`endif

  // Start condition, batch length and beat decode from registered state.
  always_comb begin
`ifdef CORK_PARTIAL_BATCH_EN
    start_ok = (stock_q != '0);
    len      = len_q;
`else
    start_ok = (stock_q >= BatchW);
    len      = BatchW;
`endif
    start    = (state_q == StIdle) & enable_i & demand_i & start_ok;
    last     = (state_q == StSend) & (sent_q == len - W'(1));
    // tx_ready never feeds tx_valid; valid depends on state only.
    hs       = (state_q == StSend) & tx.tx_ready;
  end

  // Output decode; starve looks only at IDLE so an active batch never starves.
  always_comb begin
    tx.tx_valid  = (state_q == StSend);
    tx.tx_last   = last;
    batch_done_o = (state_q == StDone);
    stock_o      = stock_q;
    overflow_o   = overflow_q;
    starve_o     = enable_i & demand_i & (state_q == StIdle) & ~start_ok;
  end

  // Stock next-state: a handshake and an add in the same cycle cancel out.
  always_comb begin
    stock_d    = stock_q;
    overflow_d = 1'b0;
    if (hs && !stock_add_i) begin
      stock_d = stock_q - W'(1);
    end else if (stock_add_i && !hs) begin
      if (stock_q < StockMaxW) begin
        stock_d = stock_q + W'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // Stock counter and overflow pulse register.
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      stock_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      stock_q    <= stock_d;
      overflow_q <= overflow_d;
    end
  end

  // Batch FSM: state, beat counter and (optionally) latched batch length.
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      state_q <= StIdle;
      sent_q  <= '0;
`ifdef CORK_PARTIAL_BATCH_EN
      len_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StSend;
            sent_q  <= '0;
`ifdef CORK_PARTIAL_BATCH_EN
            len_q   <= (stock_q < BatchW) ? stock_q : BatchW;
`endif
          end
        end
        StSend: begin
          // Valid is held until accepted; enable only matters on a handshake.
          if (hs) begin
            sent_q <= sent_q + W'(1);
            if (last) begin
              state_q <= StDone;
            end else if (!enable_i) begin
              state_q <= StPause;
            end
          end
        end
        StPause: begin
          if (enable_i) begin
            state_q <= StSend;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cork_batch_dispenser.sv
// Self-checking bench for cork_batch_dispenser: a short vector table for
// stock/starve basics, then directed multi-cycle sequences.
module tb_cork_batch_dispenser;

`ifdef CORK_PARTIAL_BATCH_EN
  localparam bit Partial = 1'b1;
`else
  localparam bit Partial = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       Nrst = 1'b0;
  logic       enable = 1'b0;
  logic       stock_add = 1'b0;
  logic       demand = 1'b0;
  logic       batch_done;
  logic [6:0] stock;
  logic       starve;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  cork_batch_dispenser_if tx_if ();

  cork_batch_dispenser dut (
    .clk          (clk),
    .Nrst         (Nrst),
    .enable_i     (enable),
    .stock_add_i  (stock_add),
    .demand_i     (demand),
    .tx           (tx_if),
    .batch_done_o (batch_done),
    .stock_o      (stock),
    .starve_o     (starve),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       add;
    logic       dem;
    logic       rdy;
    logic       exp_valid;
    logic       exp_last;
    logic       exp_done;
    logic [6:0] exp_stock;
    logic       exp_starve;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, return 1 time unit after it.
  task automatic step(input logic en, input logic add, input logic dem, input logic rdy);
    enable          = en;
    stock_add       = add;
    demand          = dem;
    tx_if.tx_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Nrst           = 1'b0;
    enable         = 1'b0;
    stock_add      = 1'b0;
    demand         = 1'b0;
    tx_if.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    Nrst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic add_stock(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int  hs;
    int  gaps;
    int  lastbad;
    int  lastpos;
    int  pausebad;
    bit  done_seen;
    logic rdy;
    logic en;

    tx_if.tx_ready = 1'b0;

    //                en add dem rdy  val last done stock starve ovf
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd2, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd3, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd3, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd4, 1'b0, 1'b0};

    // Reset state.
    do_reset();
    chk("rst valid", tx_if.tx_valid, 0);
    chk("rst last", tx_if.tx_last, 0);
    chk("rst done", batch_done, 0);
    chk("rst stock", stock, 0);
    chk("rst starve", starve, 0);
    chk("rst ovf", overflow, 0);

    // Table vectors.
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].en, vecs[i].add, vecs[i].dem, vecs[i].rdy);
      chk($sformatf("vec%0d valid", i), tx_if.tx_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d last", i), tx_if.tx_last, vecs[i].exp_last);
      chk($sformatf("vec%0d done", i), batch_done, vecs[i].exp_done);
      chk($sformatf("vec%0d stock", i), stock, vecs[i].exp_stock);
      chk($sformatf("vec%0d starve", i), starve, vecs[i].exp_starve);
      chk($sformatf("vec%0d ovf", i), overflow, vecs[i].exp_ovf);
    end

    // Stock fill: 25 corks, one full batch with ready held high.
    do_reset();
    add_stock(25);
    chk("fill stock", stock, 25);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      chk($sformatf("fill valid beat%0d", k), tx_if.tx_valid, 1);
      chk($sformatf("fill last beat%0d", k), tx_if.tx_last, (k == 20) ? 1 : 0);
      step(1'b1, 1'b0, 1'b1, 1'b1);
    end
    chk("fill done", batch_done, 1);
    chk("fill valid after", tx_if.tx_valid, 0);
    chk("fill stock after", stock, 5);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("fill done pulse", batch_done, 0);
    chk("fill starve", starve, Partial ? 0 : 1);

    // Backpressure: ready toggles, valid must stay up.
    do_reset();
    add_stock(40);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("bp start valid", tx_if.tx_valid, 1);
    hs = 0; gaps = 0; lastbad = 0; lastpos = 0; done_seen = 1'b0;
    for (int i = 0; i < 100 && !done_seen; i++) begin
      rdy = (i % 2 == 0);
      if (!tx_if.tx_valid) gaps++;
      if (tx_if.tx_last && !tx_if.tx_valid) lastbad++;
      if (tx_if.tx_valid && rdy) begin
        if (tx_if.tx_last != (hs == 19)) lastpos++;
        hs++;
      end
      step(1'b1, 1'b0, 1'b1, rdy);
      if (batch_done) done_seen = 1'b1;
    end
    chk("bp done seen", done_seen, 1);
    chk("bp handshakes", hs, 20);
    chk("bp valid gaps", gaps, 0);
    chk("bp last w/o valid", lastbad, 0);
    chk("bp last position", lastpos, 0);
    chk("bp stock", stock, 20);

    // Pause: enable low on the 7th handshake, held low for 10 cycles.
    do_reset();
    add_stock(30);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    hs = 0;
    for (int k = 0; k < 7; k++) begin
      en = (k == 6) ? 1'b0 : 1'b1;
      if (tx_if.tx_valid) hs++;
      step(en, 1'b0, 1'b1, 1'b1);
    end
    chk("pause first hs", hs, 7);
    pausebad = 0;
    if (tx_if.tx_valid) pausebad++;
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      if (tx_if.tx_valid) pausebad++;
    end
    chk("pause valid low", pausebad, 0);
    chk("pause stock", stock, 23);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("pause resume valid", tx_if.tx_valid, 1);
    hs = 0; done_seen = 1'b0; lastpos = 0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      if (tx_if.tx_valid) begin
        if (tx_if.tx_last != (hs == 12)) lastpos++;
        hs++;
      end
      step(1'b1, 1'b0, 1'b1, 1'b1);
      if (batch_done) done_seen = 1'b1;
    end
    chk("pause done seen", done_seen, 1);
    chk("pause resume beats", hs, 13);
    chk("pause last position", lastpos, 0);
    chk("pause stock final", stock, 10);

    // Saturation at StockMax, and add coinciding with a handshake.
    do_reset();
    add_stock(99);
    chk("sat stock 99", stock, 99);
    chk("sat no ovf yet", overflow, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("sat stock held", stock, 99);
    chk("sat ovf pulse", overflow, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat ovf single", overflow, 0);
    chk("sat stock still", stock, 99);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("sat send valid", tx_if.tx_valid, 1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("sat hs+add stock", stock, 99);
    chk("sat hs+add ovf", overflow, 0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("sat hs stock", stock, 98);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("net zero stock", stock, 98);
    chk("net zero ovf", overflow, 0);

    // Asynchronous reset at the 10th beat.
    do_reset();
    add_stock(30);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (9) step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("rmid valid before", tx_if.tx_valid, 1);
    chk("rmid stock before", stock, 21);
    #2;
    Nrst = 1'b0;
    #1;
    chk("rmid valid", tx_if.tx_valid, 0);
    chk("rmid last", tx_if.tx_last, 0);
    chk("rmid stock", stock, 0);
    chk("rmid done", batch_done, 0);
    @(negedge clk);
    Nrst = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("rmid idle valid", tx_if.tx_valid, 0);
    chk("rmid idle starve", starve, 1);
    chk("rmid idle stock", stock, 0);

    // Short stock: partial batch when enabled, otherwise no start.
    do_reset();
    add_stock(7);
    step(1'b1, 1'b0, 1'b1, 1'b1);
`ifdef CORK_PARTIAL_BATCH_EN
    chk("part start valid", tx_if.tx_valid, 1);
    hs = 0; done_seen = 1'b0; lastpos = 0;
    for (int i = 0; i < 20 && !done_seen; i++) begin
      if (tx_if.tx_valid) begin
        if (tx_if.tx_last != (hs == 6)) lastpos++;
        hs++;
      end
      step(1'b1, 1'b0, 1'b1, 1'b1);
      if (batch_done) done_seen = 1'b1;
    end
    chk("part done seen", done_seen, 1);
    chk("part beats", hs, 7);
    chk("part last position", lastpos, 0);
    chk("part stock", stock, 0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("part starve", starve, 1);
`else
    chk("short no valid", tx_if.tx_valid, 0);
    chk("short starve", starve, 1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("short still idle", tx_if.tx_valid, 0);
    chk("short stock", stock, 7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cork_batch_dispenser.md
# cork_batch_dispenser

Transmitting end of the cork supply path in the bottle filling/sealing line. Holds the warehouse cork stock and, when the main cork buffer signals low level, sends a batch of corks to it one per valid/ready beat. Sits between the operator stock-entry logic and the main cork buffer, which is the receiver of each beat. Runs on the divided system clock and exposes stock and alarm status for the display and alarm paths.

## Interface
- BATCH, 20: corks sent per batch.
- STOCK_MAX, 99: saturation limit of the stock counter.
- W, 7: width of the stock and beat counters.

- clk  in  1  divided system clock; all state changes on its rising edge.
- Nrst  in  1  asynchronous, active-low reset.
- enable  in  1  line running (start_stop); gates new beats and new batches.
- stock_add  in  1  one-cycle pulse; add one cork to stock.
- demand  in  1  level from the main buffer; high while the main buffer is below its minimum.
- tx_ready  in  1  main buffer accepts a cork this cycle.
- tx_valid  out  1  a cork is offered this cycle.
- tx_last  out  1  the offered cork is the final beat of the batch.
- batch_done  out  1  one-cycle pulse after the last beat of a batch.
- stock  out  W  current warehouse stock, 0..STOCK_MAX.
- starve  out  1  demand is present but no batch can start.
- overflow  out  1  one-cycle pulse when stock_add arrives at STOCK_MAX.

## Operation
- FSM states: IDLE, SEND, PAUSE, DONE. Reset state is IDLE.
- IDLE -> SEND when enable & demand & stock >= BATCH. The beat counter `sent` is cleared on this transition.
- SEND:
  - tx_valid = 1.
  - A handshake (tx_valid & tx_ready) decrements stock and increments `sent`.
  - tx_last = (sent == BATCH-1).
  - A handshake with tx_last -> DONE.
  - A handshake with enable low and not last -> PAUSE.
  - Without a handshake, tx_valid stays high whatever the enable level: valid is never withdrawn before it is accepted.
- PAUSE: tx_valid = 0. Moves to SEND when enable returns high. `sent` is kept.
- DONE: batch_done = 1 for one cycle, then -> IDLE. demand is sampled again in IDLE.
- stock_add:
  - Increments stock if stock < STOCK_MAX. Otherwise stock holds and overflow pulses.
  - stock_add in the same cycle as a handshake: stock is unchanged (net zero), and no overflow is raised.
- Stock never underflows, because a batch starts only with stock >= BATCH.
- starve = enable & demand & (state == IDLE) & (stock < BATCH). It is combinational from registered state.
- demand falling during SEND or PAUSE does not cut the batch short: every batch delivers exactly BATCH corks.

## Timing
- Reset values: state IDLE, stock 0, sent 0, tx_valid 0, tx_last 0, batch_done 0, starve 0, overflow 0.
- Reset mid-batch:
  - All outputs drop to their reset values immediately (asynchronous).
  - Any undelivered corks are lost.
  - stock is 0 after reset.
- tx_valid, tx_last and batch_done are decoded from registered state and `sent` only. There is no combinational path from tx_ready to tx_valid.
- Latency from the edge where the IDLE start condition holds to tx_valid high: 1 cycle (valid is seen from that edge onward).
- With tx_ready held high, one batch takes BATCH cycles of tx_valid, then 1 cycle of DONE. The earliest next tx_valid comes 1 cycle after DONE, giving a BATCH+2 cycle period.
- stock and overflow update on the same edge as the handshake or stock_add that causes them.

## Configuration
- Macro CORK_PARTIAL_BATCH_EN.
- Defined:
  - IDLE -> SEND needs only stock > 0.
  - The batch length is latched at start as min(stock, BATCH), and tx_last refers to that length.
  - starve asserts only when stock == 0.
- Undefined: full batches only, exactly as described in Operation.

## Test plan
- Stock fill:
  - Stimulus: reset, then 25 stock_add pulses, demand = 1, enable = 1, tx_ready = 1.
  - Required: tx_valid for 20 consecutive cycles; tx_last on the 20th; batch_done on the next cycle; stock = 5; starve = 1 afterwards.
- Backpressure:
  - Stimulus: stock 40, tx_ready toggled 1/0 each cycle.
  - Required: tx_valid held continuously; exactly 20 handshakes; stock = 20; tx_last never asserted without tx_valid.
- Pause:
  - Stimulus: enable dropped after the 7th handshake for 10 cycles.
  - Required: tx_valid = 0 during the pause; 13 further beats after enable returns; total 20; stock reduced by 20.
- Saturation:
  - Stimulus: stock at 99, then stock_add.
  - Required: stock stays 99 and overflow pulses once.
  - Stimulus: stock_add in the same cycle as a handshake.
  - Required: stock unchanged and no overflow.
- Reset:
  - Stimulus: Nrst asserted at the 10th beat.
  - Required: tx_valid = 0 and stock = 0 immediately; IDLE after release.
- CORK_PARTIAL_BATCH_EN:
  - Stimulus: stock 7, demand = 1.
  - Required: 7 beats, tx_last on the 7th, stock = 0, starve = 1.
